aes_round_ctrl: RTL
===================

Name: aes_round_ctrl

Overview:
- Iterative AES encryption round controller. Owns the 128-bit state register and the round counter.
- Drives the state into the external combinational chain SubBytes -> ShiftRows -> MixColumns. Takes back the ShiftRows and MixColumns results and applies AddRoundKey.
- Requests round keys by index from the key-schedule/round-key store.
- Sits directly downstream of MixColumns and closes the round loop.
- Valid/ready handshake on input block and output block.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256); legal values only 10, 12, 14.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  plaintext block offered
- in_ready  output  1  controller can accept a block
- in_block  input  128  plaintext; bits 127:120 = byte 0 (row0,col0), column-major byte order
- out_valid  output  1  ciphertext available
- out_ready  input  1  consumer accepts ciphertext
- out_block  output  128  ciphertext, same byte order
- state_out  output  128  current state register, to SubBytes input
- sr_in  input  128  ShiftRows result of state_out (used in final round)
- mc_in  input  128  MixColumns result of sr_in (used in rounds 1..NR-1)
- rk_round  output  4  round-key index requested this cycle
- rk  input  128  round key for rk_round, valid combinationally in the same cycle

Behaviour:
- FSM states: IDLE, ROUND, DONE. The round counter rnd is 4 bits wide.
- Reset (rst_n=0 at a clk edge) forces the following, regardless of current state (includes mid-round abort):
  - state=IDLE, rnd=0, state register=0
  - in_ready=1 (i.e. in_ready=0 only outside IDLE), out_valid=0, out_block=0, rk_round=0
- Outputs per state:
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE; out_block = state register (0 in IDLE after reset).
  - state_out = state register at all times.
  - rk_round = 0 in IDLE, rnd in ROUND, 0 in DONE.
- IDLE: on in_valid&in_ready:
  - state reg <= in_block ^ rk (rk_round=0)
  - rnd <= 1; go to ROUND
  - in_valid without the handshake changes nothing.
- ROUND, each edge:
  - if rnd < NR: state reg <= mc_in ^ rk; rnd <= rnd+1
  - if rnd == NR: state reg <= sr_in ^ rk (MixColumns bypassed); go to DONE; rnd <= 0
- DONE: hold state reg and out_valid. On out_valid&out_ready go to IDLE; in_ready=1 from the next cycle.
- No same-cycle accept of the next block in DONE. in_valid is ignored outside IDLE.
- Latency:
  - Accept edge = E0. out_valid is first high after edge E0+NR, i.e. NR cycles after acceptance.
  - Minimum initiation interval is NR+2 cycles (accept, NR rounds, output handshake cycle).
- out_block and out_valid remain stable while out_ready=0 (backpressure unbounded).
- in_block is sampled only at the accept edge; changes afterwards have no effect.
- No internal combinational path from sr_in/mc_in/rk to any output except through the state register. The path rnd -> rk_round is registered-state-only.

Test Plan:
- AES-128 (NR=10), key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready=1. Required response:
  - state_out = 00102030405060708090a0b0c0d0e0f0 one cycle after accept
  - rk_round steps 1..10 on consecutive cycles
  - out_block = 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid high exactly 10 cycles after accept
- Backpressure: same vector with out_ready=0 for 5 cycles after out_valid. Required response:
  - out_valid and out_block stay at 69c4e0d8... throughout
  - in_ready=0 throughout, including with in_valid=1 and a new block
  - after the out_ready pulse: IDLE, in_ready=1
- Back-to-back: two blocks (FIPS-197 C.1 vector, then pt=0/key=0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e). Required response:
  - second accepted on the first cycle in_ready returns high
  - both ciphertexts correct, initiation interval = 12 cycles
- Reset mid-operation: assert rst_n=0 at round 5 for 1 cycle. Required response:
  - next cycle: IDLE, in_ready=1, out_valid=0, state_out=0, rk_round=0
  - a subsequent full encryption is correct
- NR=14, key 000102...1e1f, pt 00112233445566778899aabbccddeeff. Required response:
  - out_block = 8ea2b7ca516745bfeafc49904b496089
  - rk_round reaches 14; out_valid high 14 cycles after accept
- Idle stimulus: in_valid=0 and out_ready toggling for 20 cycles after reset. Required response:
  - no state change, out_valid=0, rk_round=0

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round controller: owns the state register and round
// counter, closes the SubBytes/ShiftRows/MixColumns loop with AddRoundKey.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic [127:0] state_out,
  input  logic [127:0] sr_in,
  input  logic [127:0] mc_in,
  output logic [3:0]   rk_round,
  input  logic [127:0] rk
);

  localparam int unsigned RW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  fsm_t          fsm;
  logic [RW-1:0] rnd;
  logic [127:0]  st;

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be 10, 12 or 14");
  end

  // State register, round counter and handshake flags; rk is always indexed by rnd.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      rnd       <= '0;
      st        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            st       <= in_block ^ rk;
            rnd      <= RW'(1);
            in_ready <= 1'b0;
            fsm      <= ROUND;
          end
        end
        ROUND: begin
          if (rnd < RW'(NR)) begin
            st  <= mc_in ^ rk;
            rnd <= rnd + RW'(1);
          end else begin
            // final round skips MixColumns
            st        <= sr_in ^ rk;
            rnd       <= '0;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: begin
          fsm       <= IDLE;
          rnd       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign state_out = st;
  assign out_block = st;
  assign rk_round  = rnd;

endmodule
